// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction RAM
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_reset
);

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Depth held at 32 bits so the 16-bit count compares without truncation.
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            state;
    logic [7:0]        cnt_hi;
    logic [15:0]       cnt;
    logic [1:0]        bidx;
    logic [ADDR_W-1:0] widx;
    logic [7:0]        sum;
    logic [23:0]       shift;

    logic              xfer;
    logic [15:0]       n_hdr;
    logic [7:0]        sum_next;
    logic [15:0]       last_idx;
    logic [15:0]       widx16;

    assign xfer     = rx_valid & rx_ready;
    assign n_hdr    = {cnt_hi, rx_data};
    assign sum_next = sum + rx_data;
    assign last_idx = cnt - 16'd1;
    assign widx16   = 16'(widx);

    // Status outputs are pure decodes of the state register.
    assign rx_ready  = (state != DONE) && (state != ERR);
    assign busy      = (state != DONE) && (state != ERR);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign cpu_reset = (state != DONE);

    // Loader FSM: header parse, word assembly with one-deep write register, checksum verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HDR_HI;
            cnt_hi <= 8'd0;
            cnt    <= 16'd0;
            bidx   <= 2'd0;
            widx   <= '0;
            sum    <= 8'd0;
            shift  <= 24'd0;
            we     <= 1'b0;
            wa     <= '0;
            wd     <= 32'd0;
        end else begin
            // The strobe lasts exactly one cycle; wa/wd keep their last values.
            we <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (xfer) begin
                        cnt_hi <= rx_data;
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        cnt <= n_hdr;
                        if ({16'd0, n_hdr} > DEPTH) begin
                            state <= ERR;
                        end else if (n_hdr == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shift <= {shift[15:0], rx_data};
                        sum   <= sum_next;
                        bidx  <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            we   <= 1'b1;
                            wa   <= widx;
                            wd   <= {shift, rx_data};
                            widx <= widx + ADDR_W'(1);
                            if (widx16 == last_idx) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        state <= (sum_next == 8'd0) ? DONE : ERR;
                    end
                end
                default: begin
                    // DONE and ERR are terminal until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        we;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_reset;

    imem_loader #(.ADDR_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_reset (cpu_reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0]  stim[$];
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          we_cyc[$];
    int          we_not_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every write strobe seen between edges.
    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(wa);
            wd_q.push_back(wd);
            we_cyc.push_back(cyc);
            if (!rx_ready) we_not_ready++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        we_cyc.delete();
        we_not_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_log();
    endtask

    // Send one byte; returns number of cycles spent waiting for rx_ready.
    task automatic send(input logic [7:0] b, input bit gaps, output int stalls);
        int t;
        stalls = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        stalls = t;
        if (!rx_ready) begin
            check("send_timeout", 32'(rx_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_stim(input bit gaps, output int total_stalls);
        int s;
        total_stalls = 0;
        foreach (stim[i]) begin
            send(stim[i], gaps, s);
            total_stalls += s;
        end
    endtask

    // Scenario 2 image: N=2, words 20020001 20030002.
    // Data sum = 20+02+00+01+20+03+00+02 = 0x48, so good CSUM = 0xB8.
    task automatic load_scen2();
        stim = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h01, 8'h20, 8'h03, 8'h00, 8'h02, 8'hB8};
    endtask

    task automatic check_scen2_writes(input string tag);
        check({tag, "_nwr"}, wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_wa0"}, 32'(wa_q[0]), 32'd0);
            check({tag, "_wd0"}, wd_q[0], 32'h20020001);
            check({tag, "_wa1"}, 32'(wa_q[1]), 32'd1);
            check({tag, "_wd1"}, wd_q[1], 32'h20030002);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    endtask

    initial begin
        int st;

        // Reset state
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", 32'(rx_ready), 32'd1);
        check("rst_we", 32'(we), 32'd0);
        check("rst_wa", 32'(wa), 32'd0);
        check("rst_wd", wd, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpurst", 32'(cpu_reset), 32'd1);

        // 1: single word 24080005; data sum 0x31 -> CSUM 0xCF; CSUM follows last byte directly.
        do_reset();
        stim = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'hCF};
        send_stim(1'b0, st);
        check("t1_nwr", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            check("t1_wa", 32'(wa_q[0]), 32'd0);
            check("t1_wd", wd_q[0], 32'h24080005);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_ready", 32'(rx_ready), 32'd0);
        check("t1_cpurst", 32'(cpu_reset), 32'd0);
        check("t1_wa_hold", 32'(wa), 32'd0);
        check("t1_wd_hold", wd, 32'h24080005);

        // 2: two words back-to-back, writes 4 cycles apart, no stall.
        do_reset();
        load_scen2();
        send_stim(1'b0, st);
        check_scen2_writes("t2");
        check("t2_stalls", st, 32'd0);
        check("t2_we_rdy", we_not_ready, 32'd0);
        if (we_cyc.size() == 2) check("t2_spacing", we_cyc[1] - we_cyc[0], 32'd4);

        // 3: bad checksum 0xDA (0x31+0xDA=0x0B): write happens, then ERR.
        do_reset();
        stim = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'hDA};
        send_stim(1'b0, st);
        check("t3_nwr", wa_q.size(), 32'd1);
        if (wd_q.size() == 1) check("t3_wd", wd_q[0], 32'h24080005);
        check("t3_err", 32'(err), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_cpurst", 32'(cpu_reset), 32'd1);
        check("t3_ready", 32'(rx_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // 4a: N=1025 exceeds depth -> ERR right after CNT_LO, no write.
        do_reset();
        stim = '{8'h04, 8'h01};
        send_stim(1'b0, st);
        check("t4a_err", 32'(err), 32'd1);
        check("t4a_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4a_nwr", wa_q.size(), 32'd0);

        // 4b: N=1024 is exactly the depth -> still accepted (stays busy in DATA).
        do_reset();
        stim = '{8'h04, 8'h00};
        send_stim(1'b0, st);
        check("t4b_err", 32'(err), 32'd0);
        check("t4b_busy", 32'(busy), 32'd1);

        // 4c: N=0 then CSUM 00 -> DONE with no writes.
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00};
        send_stim(1'b0, st);
        check("t4c_done", 32'(done), 32'd1);
        check("t4c_nwr", wa_q.size(), 32'd0);

        // 5: scenario 2 with random rx_valid gaps.
        do_reset();
        load_scen2();
        send_stim(1'b1, st);
        repeat (2) @(posedge clk);
        #1;
        check_scen2_writes("t5");

        // 6: reset after 6 bytes of scenario 2, then resend in full.
        do_reset();
        load_scen2();
        for (int i = 0; i < 6; i++) send(stim[i], 1'b0, st);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_we", 32'(we), 32'd0);
        check("t6_cpurst", 32'(cpu_reset), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_ready", 32'(rx_ready), 32'd1);
        clear_log();
        send_stim(1'b0, st);
        check_scen2_writes("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
